reg_xfer_sequencer: RTL and testbench
=====================================

// Module: reg_xfer_sequencer
// PURPOSE
//  Command-level controller for the 8x16 register bank. Accepts one register-transfer
//  command at a time over a valid/ready handshake and drives the bank's move/in strobes,
//  src/dst selects and input data. A SWAP command is expanded into three bank moves
//  through a scratch register.
//  Guarantees the bank never sees move and in asserted together.
// PARAMETERS
//  BANK_LAT  2  cycles after a strobe before the bank write is committed; selects held stable
//  SCRATCH   7  register index used as temporary by SWAP (0..7)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   sequencer can accept a command (high only in IDLE)
//  cmd_op     in   2   00 NOP, 01 IN, 10 MOVE, 11 SWAP
//  cmd_src    in   3   source register (MOVE/SWAP)
//  cmd_dst    in   3   destination register (IN/MOVE/SWAP)
//  cmd_data   in   16  write data for IN
//  bank_dout  in   16  bank data output
//  bank_move  out  1   one-cycle move strobe to bank
//  bank_in    out  1   one-cycle input strobe to bank
//  bank_src   out  3   bank source select
//  bank_dst   out  3   bank destination select
//  bank_din   out  16  bank input data
//  busy       out  1   command in progress (not IDLE)
//  done       out  1   one-cycle pulse on command completion
//  err        out  1   one-cycle pulse, coincident with done, on rejected command
//  rsp_data   out  16  bank_dout sampled in the DONE cycle; holds until next done
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; cmd_ready=1; all other outputs 0. A command in
//    flight is abandoned and strobes drop immediately; no replay after reset release.
//  - Accept: cmd_valid & cmd_ready at a rising edge latches op/src/dst/data; cmd_ready=0 next cycle.
//  - FSM: IDLE -> ISSUE -> WAIT -> (ISSUE for next SWAP step | DONE) -> IDLE.
//  - ISSUE (1 cycle): exactly one of bank_move/bank_in = 1; src/dst/din driven.
//  - WAIT (BANK_LAT cycles, down-counter): strobes 0; src/dst/din held at ISSUE values.
//  - DONE (1 cycle): done=1, rsp_data<=bank_dout; then IDLE, cmd_ready=1.
//  - Latency, accept edge = cycle 0: IN/MOVE done in cycle 2+BANK_LAT (4 at default).
//    SWAP done in cycle 1+3*(1+BANK_LAT) (10 at default).
//  - IN: bank_in, bank_dst=dst, bank_din=data. MOVE: bank_move, bank_src=src, bank_dst=dst.
//  - MOVE with src==dst is legal and executed as one normal move.
//  - SWAP steps: src->SCRATCH, dst->src, SCRATCH->dst. SCRATCH contents are clobbered.
//  - NOP: IDLE -> DONE directly; done in cycle 1; no strobe.
//  - Rejected (err): SWAP with src==dst, src==SCRATCH or dst==SCRATCH.
//    IDLE -> DONE with err=1, no bank strobe, rsp_data still updated.
//  - cmd_* ignored while busy; a held cmd_valid is accepted on the first IDLE cycle.
//  - Invariant: bank_move & bank_in never both 1; at most one strobe per ISSUE cycle.
// CONFIGURATION
//  - XFER_SWAP_EN defined: SWAP executes as above.
//  - XFER_SWAP_EN undefined: SWAP rejected (done+err in cycle 1, no bank activity).
//    SCRATCH is unused and SWAP step logic is not built.
// TESTING
//  - Reset mid-WAIT of IN: rst_n=0 at cycle 2 -> strobes/busy/done 0 same cycle.
//    After release cmd_ready=1; no strobe and no done are issued.
//  - IN dst=3 data=16'hBEEF -> bank_in=1 only in cycle 1 with bank_dst=3, bank_din=BEEF.
//    done in cycle 4; bank model R3=BEEF.
//  - MOVE src=3 dst=5 after previous -> bank_move cycle 1, bank_src=3, bank_dst=5.
//    done cycle 4; R5=BEEF; rsp_data=BEEF.
//  - SWAP src=1(0x0011) dst=2(0x0022), XFER_SWAP_EN -> three bank_move pulses, cycles 1/4/7.
//    done cycle 10; R1=0x0022, R2=0x0011.
//  - SWAP src=dst=4, or dst=7 -> done+err cycle 1, zero strobes.
//    Without XFER_SWAP_EN any SWAP gives the same response.
//  - Back-to-back: cmd_valid held with 4 INs -> one accept per IDLE; never move&in together.
//    Four done pulses, each 5 cycles apart at BANK_LAT=2.

Source files
------------

// File: rtl/reg_xfer_sequencer_if.sv
// rtl/reg_xfer_sequencer_if.sv - command handshake and register-bank bus for reg_xfer_sequencer
interface reg_xfer_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_src;
  logic [2:0]  cmd_dst;
  logic [15:0] cmd_data;
  logic [15:0] bank_dout;
  logic        bank_move;
  logic        bank_in;
  logic [2:0]  bank_src;
  logic [2:0]  bank_dst;
  logic [15:0] bank_din;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_data, bank_dout,
    input  cmd_ready, bank_move, bank_in, bank_src, bank_dst, bank_din,
    input  busy, done, err, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_data, bank_dout,
    output cmd_ready, bank_move, bank_in, bank_src, bank_dst, bank_din,
    output busy, done, err, rsp_data
  );
endinterface

// File: rtl/reg_xfer_sequencer.sv
// rtl/reg_xfer_sequencer.sv - command sequencer driving an 8x16 register bank
// Optional feature macro: XFER_SWAP_EN (SWAP executed as three moves via a scratch register).
module reg_xfer_sequencer #(
  parameter int BANK_LAT = 2,
  parameter int SCRATCH  = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_xfer_sequencer_if.slave  xf
);
  localparam int CW = $clog2(BANK_LAT + 1);
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_IN   = 2'b01;
  localparam logic [1:0] OP_MOVE = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_op;
  logic [2:0]  r_src;
  logic [2:0]  r_dst;
  logic [15:0] r_data;
  logic        r_err;
  logic [CW-1:0] r_cnt;
  logic [15:0] r_rsp;
  logic        w_accept;
  logic        w_reject;
  logic        w_last_step;

  assign w_accept = xf.cmd_valid && (r_state == S_IDLE);

`ifdef XFER_SWAP_EN
  localparam logic [2:0] SCR = 3'(SCRATCH);
  logic [1:0] r_step;

  assign w_reject = (xf.cmd_op == OP_SWAP) &&
                    ((xf.cmd_src == xf.cmd_dst) || (xf.cmd_src == SCR) || (xf.cmd_dst == SCR));
  assign w_last_step = (r_op != OP_SWAP) || (r_step == 2'd2);
`else
  assign w_reject    = (xf.cmd_op == OP_SWAP);
  assign w_last_step = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = ((xf.cmd_op == OP_NOP) || w_reject) ? S_DONE : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_next = w_last_step ? S_DONE : S_ISSUE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes decode from state only, so an async reset removes them in the same cycle.
  always_comb begin
    xf.cmd_ready = (r_state == S_IDLE);
    xf.busy      = (r_state != S_IDLE);
    xf.done      = (r_state == S_DONE);
    xf.err       = (r_state == S_DONE) && r_err;
    xf.bank_in   = (r_state == S_ISSUE) && (r_op == OP_IN);
    xf.bank_move = (r_state == S_ISSUE) && ((r_op == OP_MOVE) || (r_op == OP_SWAP));
    xf.rsp_data  = r_rsp;
    xf.bank_src  = 3'd0;
    xf.bank_dst  = 3'd0;
    xf.bank_din  = 16'd0;
    case (r_op)
      OP_IN: begin
        xf.bank_dst = r_dst;
        xf.bank_din = r_data;
      end
      OP_MOVE: begin
        xf.bank_src = r_src;
        xf.bank_dst = r_dst;
      end
`ifdef XFER_SWAP_EN
      OP_SWAP: begin
        case (r_step)
          2'd0:    begin xf.bank_src = r_src; xf.bank_dst = SCR;   end
          2'd1:    begin xf.bank_src = r_dst; xf.bank_dst = r_src; end
          default: begin xf.bank_src = SCR;   xf.bank_dst = r_dst; end
        endcase
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= OP_NOP;
      r_src  <= 3'd0;
      r_dst  <= 3'd0;
      r_data <= 16'd0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
      r_rsp  <= 16'd0;
    end else begin
      if (w_accept) begin
        r_op   <= xf.cmd_op;
        r_src  <= xf.cmd_src;
        r_dst  <= xf.cmd_dst;
        r_data <= xf.cmd_data;
        r_err  <= w_reject;
      end
      if (r_state == S_ISSUE)                  r_cnt <= CW'(BANK_LAT - 1);
      else if (r_state == S_WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (r_state == S_DONE) r_rsp <= xf.bank_dout;
    end
  end

`ifdef XFER_SWAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                     r_step <= 2'd0;
    else if (w_accept)                                              r_step <= 2'd0;
    else if (r_state == S_WAIT && r_cnt == '0 && !w_last_step)      r_step <= r_step + 2'd1;
  end
`endif
endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// tb/tb_reg_xfer_sequencer.sv - directed self-checking bench for reg_xfer_sequencer
module tb_reg_xfer_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  reg_xfer_sequencer_if xf();
  reg_xfer_sequencer #(.BANK_LAT(2), .SCRATCH(7)) dut (.clk(clk), .rst_n(rst_n), .xf(xf));

  always #5 clk = ~clk;

  logic [15:0] mem [8];
  logic [15:0] p_val;
  logic [2:0]  p_dst;
  int          p_cnt = 0;

  assign xf.bank_dout = mem[xf.bank_src];

  // Bank commits a write two edges after the strobe edge.
  always @(posedge clk) begin
    if (p_cnt == 1) mem[p_dst] <= p_val;
    if (xf.bank_in || xf.bank_move) begin
      p_cnt <= 2;
      p_dst <= xf.bank_dst;
      p_val <= xf.bank_in ? xf.bank_din : mem[xf.bank_src];
    end else if (p_cnt != 0) begin
      p_cnt <= p_cnt - 1;
    end
  end

  int          n_in, n_move, n_both;
  int          str_cyc[$];
  logic [2:0]  str_src[$];
  logic [2:0]  str_dst[$];
  logic [15:0] str_din[$];
  int          done_q[$];
  logic        last_err;

  task automatic clear_rec();
    n_in = 0; n_move = 0; n_both = 0;
    str_cyc.delete(); str_src.delete(); str_dst.delete(); str_din.delete();
    done_q.delete(); last_err = 1'b0;
  endtask

  task automatic sample(input int c);
    if (xf.bank_in) n_in++;
    if (xf.bank_move) n_move++;
    if (xf.bank_in && xf.bank_move) n_both++;
    if (xf.bank_in || xf.bank_move) begin
      str_cyc.push_back(c); str_src.push_back(xf.bank_src);
      str_dst.push_back(xf.bank_dst); str_din.push_back(xf.bank_din);
    end
    if (xf.done) begin done_q.push_back(c); last_err = xf.err; end
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                       input logic [15:0] data);
    clear_rec();
    xf.cmd_valid = 1'b1; xf.cmd_op = op; xf.cmd_src = src; xf.cmd_dst = dst; xf.cmd_data = data;
    @(posedge clk); #1;
    xf.cmd_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int c = 1; c <= n; c++) begin
      sample(c);
      @(posedge clk); #1;
    end
  endtask

  function automatic int q0(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  task automatic test_reset();
    checks++; if (xf.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", xf.cmd_ready); end
    checks++; if ({xf.busy, xf.done, xf.err, xf.bank_in, xf.bank_move} !== 5'b0) begin errors++;
      $display("FAIL reset_flags got=%b exp=00000", {xf.busy, xf.done, xf.err, xf.bank_in, xf.bank_move}); end
    checks++; if ({xf.bank_src, xf.bank_dst, xf.bank_din, xf.rsp_data} !== 38'd0) begin errors++;
      $display("FAIL reset_buses got=%h exp=0", {xf.bank_src, xf.bank_dst, xf.bank_din, xf.rsp_data}); end
  endtask

  task automatic test_reset_mid_wait();
    issue(2'b01, 3'd0, 3'd6, 16'h1234);
    run(1);
    rst_n = 1'b0; #1;
    checks++; if ({xf.busy, xf.done, xf.bank_in, xf.bank_move} !== 4'b0) begin errors++;
      $display("FAIL rst_mid_drop got=%b exp=0000", {xf.busy, xf.done, xf.bank_in, xf.bank_move}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    clear_rec();
    run(6);
    checks++; if (xf.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", xf.cmd_ready); end
    checks++; if (n_in + n_move !== 0) begin errors++; $display("FAIL rst_mid_strobes got=%0d exp=0", n_in + n_move); end
    checks++; if (done_q.size() !== 0) begin errors++; $display("FAIL rst_mid_done got=%0d exp=0", done_q.size()); end
  endtask

  task automatic test_in();
    issue(2'b01, 3'd0, 3'd3, 16'hBEEF);
    run(5);
    checks++; if (n_in !== 1 || n_move !== 0) begin errors++; $display("FAIL in_strobes got=%0d/%0d exp=1/0", n_in, n_move); end
    checks++; if (q0(str_cyc) !== 1) begin errors++; $display("FAIL in_cycle got=%0d exp=1", q0(str_cyc)); end
    checks++; if (str_dst.size() == 0 || str_dst[0] !== 3'd3 || str_din[0] !== 16'hBEEF) begin errors++;
      $display("FAIL in_sel got=%p/%p exp=3/beef", str_dst, str_din); end
    checks++; if (done_q.size() !== 1 || q0(done_q) !== 4 || last_err !== 1'b0) begin errors++;
      $display("FAIL in_done got=%0d err=%b exp=4 err=0", q0(done_q), last_err); end
    checks++; if (mem[3] !== 16'hBEEF) begin errors++; $display("FAIL in_bank got=%h exp=beef", mem[3]); end
  endtask

  task automatic test_move();
    issue(2'b10, 3'd3, 3'd5, 16'h0);
    run(5);
    checks++; if (n_move !== 1 || n_in !== 0 || q0(str_cyc) !== 1) begin errors++;
      $display("FAIL mv_strobes got=%0d/%0d at %0d exp=1/0 at 1", n_move, n_in, q0(str_cyc)); end
    checks++; if (str_src.size() == 0 || str_src[0] !== 3'd3 || str_dst[0] !== 3'd5) begin errors++;
      $display("FAIL mv_sel got=%p/%p exp=3/5", str_src, str_dst); end
    checks++; if (q0(done_q) !== 4) begin errors++; $display("FAIL mv_done got=%0d exp=4", q0(done_q)); end
    checks++; if (mem[5] !== 16'hBEEF) begin errors++; $display("FAIL mv_bank got=%h exp=beef", mem[5]); end
    checks++; if (xf.rsp_data !== 16'hBEEF) begin errors++; $display("FAIL mv_rsp got=%h exp=beef", xf.rsp_data); end
    issue(2'b10, 3'd5, 3'd5, 16'h0);
    run(5);
    checks++; if (n_move !== 1 || q0(done_q) !== 4 || last_err !== 1'b0) begin errors++;
      $display("FAIL mv_same got=%0d done=%0d err=%b exp=1 done=4 err=0", n_move, q0(done_q), last_err); end
  endtask

  task automatic test_nop();
    issue(2'b00, 3'd0, 3'd0, 16'h0);
    run(3);
    checks++; if (q0(done_q) !== 1 || last_err !== 1'b0 || n_in + n_move !== 0) begin errors++;
      $display("FAIL nop got=done%0d err=%b str=%0d exp=done1 err=0 str=0", q0(done_q), last_err, n_in + n_move); end
  endtask

  task automatic test_swap();
    int exp_c[3] = '{1, 4, 7};
    logic [2:0] exp_s[3] = '{3'd1, 3'd2, 3'd7};
    logic [2:0] exp_d[3] = '{3'd7, 3'd1, 3'd2};
    issue(2'b01, 3'd0, 3'd1, 16'h0011); run(5);
    issue(2'b01, 3'd0, 3'd2, 16'h0022); run(5);
    issue(2'b11, 3'd1, 3'd2, 16'h0);
    run(12);
`ifdef XFER_SWAP_EN
    checks++; if (n_move !== 3 || n_in !== 0) begin errors++; $display("FAIL swap_count got=%0d/%0d exp=3/0", n_move, n_in); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (str_cyc.size() <= i || str_cyc[i] !== exp_c[i] || str_src[i] !== exp_s[i] || str_dst[i] !== exp_d[i]) begin
        errors++; $display("FAIL swap_step%0d got=%p %p %p exp=%0d %0d %0d", i, str_cyc, str_src, str_dst,
                           exp_c[i], exp_s[i], exp_d[i]);
      end
    end
    checks++; if (q0(done_q) !== 10 || last_err !== 1'b0) begin errors++;
      $display("FAIL swap_done got=%0d err=%b exp=10 err=0", q0(done_q), last_err); end
    checks++; if (mem[1] !== 16'h0022 || mem[2] !== 16'h0011) begin errors++;
      $display("FAIL swap_bank got=%h/%h exp=0022/0011", mem[1], mem[2]); end
`else
    checks++; if (q0(done_q) !== 1 || last_err !== 1'b1 || n_in + n_move !== 0) begin errors++;
      $display("FAIL swap_off got=done%0d err=%b str=%0d exp=done1 err=1 str=0", q0(done_q), last_err, n_in + n_move); end
    checks++; if (mem[1] !== 16'h0011 || mem[2] !== 16'h0022) begin errors++;
      $display("FAIL swap_off_bank got=%h/%h exp=0011/0022", mem[1], mem[2]); end
`endif
  endtask

  task automatic test_swap_reject();
    logic [2:0] srcs[3] = '{3'd4, 3'd1, 3'd7};
    logic [2:0] dsts[3] = '{3'd4, 3'd7, 3'd2};
    for (int i = 0; i < 3; i++) begin
      issue(2'b11, srcs[i], dsts[i], 16'h0);
      run(3);
      checks++;
      if (q0(done_q) !== 1 || done_q.size() !== 1 || last_err !== 1'b1 || n_in + n_move !== 0) begin
        errors++; $display("FAIL swap_rej%0d got=done%0d err=%b str=%0d exp=done1 err=1 str=0",
                           i, q0(done_q), last_err, n_in + n_move);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    logic will_acc;
    clear_rec();
    xf.cmd_valid = 1'b1; xf.cmd_op = 2'b01; xf.cmd_src = 3'd0; xf.cmd_dst = 3'd0; xf.cmd_data = 16'hA000;
    for (int c = 0; c < 25; c++) begin
      will_acc = xf.cmd_valid && xf.cmd_ready;
      sample(c);
      @(posedge clk); #1;
      if (will_acc) begin
        acc++;
        if (acc == 4) xf.cmd_valid = 1'b0;
        else begin xf.cmd_dst = 3'(acc); xf.cmd_data = 16'hA000 + 16'(acc); end
      end
    end
    checks++; if (acc !== 4 || n_in !== 4) begin errors++; $display("FAIL b2b_accepts got=%0d/%0d exp=4/4", acc, n_in); end
    checks++; if (n_both !== 0) begin errors++; $display("FAIL b2b_overlap got=%0d exp=0", n_both); end
    checks++; if (done_q.size() !== 4) begin errors++; $display("FAIL b2b_dones got=%0d exp=4", done_q.size()); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (done_q.size() <= i || done_q[i] - done_q[i-1] !== 5) begin
        errors++; $display("FAIL b2b_gap%0d got=%p exp=5 apart", i, done_q);
      end
    end
    checks++; if (mem[0] !== 16'hA000 || mem[3] !== 16'hA003) begin errors++;
      $display("FAIL b2b_bank got=%h/%h exp=a000/a003", mem[0], mem[3]); end
  endtask

  initial begin
    xf.cmd_valid = 1'b0; xf.cmd_op = 2'b00; xf.cmd_src = 3'd0; xf.cmd_dst = 3'd0; xf.cmd_data = 16'h0;
    #12;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset_mid_wait();
    test_in();
    test_move();
    test_nop();
    test_swap();
    test_swap_reject();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
